// File: rtl/rob_if.sv
// Signal bundle between the reorder buffer and the decoder, the CDB producers and the
// register file. The master side drives issue, CDB and query ids. The slave side is the ROB.
interface rob_if #(parameter int ROB_SIZE_BIT = 3);
    logic                    issue_valid;
    logic [4:0]              issue_rd;
    logic                    issue_is_br;
    logic                    issue_pred_taken;
    logic [31:0]             issue_alt_pc;
    logic                    rob_full;
    logic [ROB_SIZE_BIT-1:0] rob_tail_id;

    logic                    cdb_valid;
    logic [ROB_SIZE_BIT-1:0] cdb_rob_id;
    logic [31:0]             cdb_value;
    logic                    cdb_taken;

    logic [ROB_SIZE_BIT-1:0] qry1_id;
    logic [ROB_SIZE_BIT-1:0] qry2_id;
    logic                    qry1_ready;
    logic [31:0]             qry1_value;
    logic                    qry2_ready;
    logic [31:0]             qry2_value;

    logic                    commit_valid;
    logic [4:0]              commit_rd;
    logic [31:0]             commit_value;
    logic [ROB_SIZE_BIT-1:0] commit_rob_id;
    logic                    flush_out;
    logic [31:0]             flush_pc;

    modport master (
        output issue_valid, issue_rd, issue_is_br, issue_pred_taken, issue_alt_pc,
        output cdb_valid, cdb_rob_id, cdb_value, cdb_taken,
        output qry1_id, qry2_id,
        input  rob_full, rob_tail_id,
        input  qry1_ready, qry1_value, qry2_ready, qry2_value,
        input  commit_valid, commit_rd, commit_value, commit_rob_id,
        input  flush_out, flush_pc
    );

    modport slave (
        input  issue_valid, issue_rd, issue_is_br, issue_pred_taken, issue_alt_pc,
        input  cdb_valid, cdb_rob_id, cdb_value, cdb_taken,
        input  qry1_id, qry2_id,
        output rob_full, rob_tail_id,
        output qry1_ready, qry1_value, qry2_ready, qry2_value,
        output commit_valid, commit_rd, commit_value, commit_rob_id,
        output flush_out, flush_pc
    );
endinterface

// File: rtl/rob.sv
// Circular reorder buffer with in-order commit and branch-mispredict flush.
// Define ROB_CDB_BYPASS_EN to let a CDB result commit and forward to queries in the same cycle.
module rob #(
    parameter int ROB_SIZE_BIT = 3
) (
    input  logic   clk_in,
    input  logic   rst_in,
    input  logic   rdy_in,
    rob_if.slave   bus
);
    localparam int N = 1 << ROB_SIZE_BIT;
    localparam logic [ROB_SIZE_BIT:0] FULL_COUNT = (ROB_SIZE_BIT+1)'(N);

    typedef logic [ROB_SIZE_BIT-1:0] id_t;

    logic [N-1:0]      r_busy;
    logic [N-1:0]      r_ready;
    logic [N-1:0]      r_isBr;
    logic [N-1:0]      r_predTaken;
    logic [N-1:0]      r_taken;
    logic [4:0]        r_rd    [N];
    logic [31:0]       r_value [N];
    logic [31:0]       r_altPc [N];
    id_t               r_head;
    id_t               r_tail;
    logic [ROB_SIZE_BIT:0] r_count;

    logic        w_full;
    logic        w_issue;
    logic        w_cdb;
    logic        w_cdbHead;
    logic        w_commit;
    logic        w_headTaken;
    logic [31:0] w_headValue;
    logic        w_mispredict;

    assign w_full           = (r_count == FULL_COUNT);
    assign bus.rob_full     = w_full;
    assign bus.rob_tail_id  = r_tail;

    assign w_issue = rdy_in & bus.issue_valid & ~w_full;
    assign w_cdb   = rdy_in & bus.cdb_valid & r_busy[bus.cdb_rob_id];

`ifdef ROB_CDB_BYPASS_EN
    assign w_cdbHead = w_cdb & (bus.cdb_rob_id == r_head);
`else
    assign w_cdbHead = 1'b0;
`endif

    // A result arriving on the CDB for the head takes priority over the stored copy.
    assign w_commit     = rdy_in & r_busy[r_head] & (r_ready[r_head] | w_cdbHead);
    assign w_headTaken  = w_cdbHead ? bus.cdb_taken : r_taken[r_head];
    assign w_headValue  = w_cdbHead ? bus.cdb_value : r_value[r_head];
    assign w_mispredict = w_commit & r_isBr[r_head] & (w_headTaken != r_predTaken[r_head]);

    always_comb begin
        bus.qry1_ready = r_busy[bus.qry1_id] & r_ready[bus.qry1_id];
        bus.qry1_value = r_busy[bus.qry1_id] ? r_value[bus.qry1_id] : 32'd0;
        bus.qry2_ready = r_busy[bus.qry2_id] & r_ready[bus.qry2_id];
        bus.qry2_value = r_busy[bus.qry2_id] ? r_value[bus.qry2_id] : 32'd0;
`ifdef ROB_CDB_BYPASS_EN
        if (bus.cdb_valid && (bus.cdb_rob_id == bus.qry1_id)) begin
            bus.qry1_ready = 1'b1;
            bus.qry1_value = bus.cdb_value;
        end
        if (bus.cdb_valid && (bus.cdb_rob_id == bus.qry2_id)) begin
            bus.qry2_ready = 1'b1;
            bus.qry2_value = bus.cdb_value;
        end
`endif
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_busy            <= '0;
            r_ready           <= '0;
            r_head            <= '0;
            r_tail            <= '0;
            r_count           <= '0;
            bus.commit_valid  <= 1'b0;
            bus.commit_rd     <= '0;
            bus.commit_value  <= '0;
            bus.commit_rob_id <= '0;
            bus.flush_out     <= 1'b0;
            bus.flush_pc      <= '0;
        end else begin
            bus.commit_valid <= 1'b0;
            bus.flush_out    <= 1'b0;
            if (w_mispredict) begin
                // Everything younger than the branch is wrong-path work; drop it all.
                bus.commit_valid  <= 1'b1;
                bus.commit_rd     <= '0;
                bus.commit_value  <= w_headValue;
                bus.commit_rob_id <= r_head;
                bus.flush_out     <= 1'b1;
                bus.flush_pc      <= r_altPc[r_head];
                r_busy            <= '0;
                r_ready           <= '0;
                r_head            <= '0;
                r_tail            <= '0;
                r_count           <= '0;
            end else begin
                if (w_issue) begin
                    r_busy[r_tail]      <= 1'b1;
                    r_ready[r_tail]     <= 1'b0;
                    r_rd[r_tail]        <= bus.issue_rd;
                    r_isBr[r_tail]      <= bus.issue_is_br;
                    r_predTaken[r_tail] <= bus.issue_pred_taken;
                    r_altPc[r_tail]     <= bus.issue_alt_pc;
                    r_value[r_tail]     <= '0;
                    r_taken[r_tail]     <= 1'b0;
                    r_tail              <= r_tail + id_t'(1);
                end
                if (w_cdb) begin
                    r_ready[bus.cdb_rob_id] <= 1'b1;
                    r_value[bus.cdb_rob_id] <= bus.cdb_value;
                    r_taken[bus.cdb_rob_id] <= bus.cdb_taken;
                end
                if (w_commit) begin
                    bus.commit_valid  <= 1'b1;
                    bus.commit_rd     <= r_rd[r_head];
                    bus.commit_value  <= w_headValue;
                    bus.commit_rob_id <= r_head;
                    r_busy[r_head]    <= 1'b0;
                    r_head            <= r_head + id_t'(1);
                end
                r_count <= r_count + (ROB_SIZE_BIT+1)'(w_issue) - (ROB_SIZE_BIT+1)'(w_commit);
            end
        end
    end
endmodule

// File: tb/tb_rob.sv
// Testbench for rob: directed vector table, hand-written corner sequences and random traffic
// checked against a queue-based model of the buffer.
module tb_rob;
    localparam int B = 3;
    localparam int N = 8;
`ifdef ROB_CDB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    always #5 clk = ~clk;

    rob_if #(.ROB_SIZE_BIT(B)) bus();

    rob #(.ROB_SIZE_BIT(B)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: the live entries in program order, oldest first.
    typedef struct {
        logic [2:0]  id;
        logic [4:0]  rd;
        bit          isBr;
        bit          pred;
        logic [31:0] alt;
        bit          done;
        logic [31:0] value;
        bit          taken;
    } ent_t;

    ent_t        mq[$];
    int          mTail = 0;
    logic        eCv = 1'b0, eFl = 1'b0;
    logic [4:0]  eRd = '0;
    logic [31:0] eVal = '0, ePc = '0;
    logic [2:0]  eId = '0;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int findId(input logic [2:0] id);
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].id == id) return i;
        return -1;
    endfunction

    function automatic void qryExp(input logic [2:0] q, output logic r, output logic [31:0] v);
        int idx;
        idx = findId(q);
        r = (idx >= 0) && mq[idx].done;
        v = (idx >= 0) ? mq[idx].value : 32'd0;
        if (BYPASS && bus.cdb_valid && bus.cdb_rob_id == q) begin
            r = 1'b1;
            v = bus.cdb_value;
        end
    endfunction

    task automatic checkQuery();
        logic        r;
        logic [31:0] v;
        checkVal("rob_full", bus.rob_full, (mq.size() == N));
        checkVal("rob_tail_id", bus.rob_tail_id, mTail);
        qryExp(bus.qry1_id, r, v);
        checkVal("qry1_ready", bus.qry1_ready, r);
        checkVal("qry1_value", bus.qry1_value, v);
        qryExp(bus.qry2_id, r, v);
        checkVal("qry2_ready", bus.qry2_ready, r);
        checkVal("qry2_value", bus.qry2_value, v);
    endtask

    task automatic modelEdge();
        bit          doCommit, issueOk;
        int          ci;
        logic [31:0] hv;
        bit          ht;
        ent_t        e;
        if (rst) begin
            mq.delete();
            mTail = 0;
            eCv = 0; eRd = 0; eVal = 0; eId = 0; eFl = 0; ePc = 0;
        end else if (!rdy) begin
            eCv = 0;
            eFl = 0;
        end else begin
            issueOk  = bus.issue_valid && (mq.size() < N);
            ci       = bus.cdb_valid ? findId(bus.cdb_rob_id) : -1;
            doCommit = 0;
            hv       = '0;
            ht       = 0;
            eCv      = 0;
            eFl      = 0;
            if (mq.size() > 0) begin
                if (BYPASS && ci == 0) begin
                    doCommit = 1; hv = bus.cdb_value; ht = bus.cdb_taken;
                end else if (mq[0].done) begin
                    doCommit = 1; hv = mq[0].value; ht = mq[0].taken;
                end
            end
            if (doCommit && mq[0].isBr && (ht != mq[0].pred)) begin
                eCv = 1; eRd = 0; eVal = hv; eId = mq[0].id; eFl = 1; ePc = mq[0].alt;
                mq.delete();
                mTail = 0;
            end else begin
                if (ci >= 0) begin
                    mq[ci].done  = 1;
                    mq[ci].value = bus.cdb_value;
                    mq[ci].taken = bus.cdb_taken;
                end
                if (doCommit) begin
                    eCv = 1; eRd = mq[0].rd; eVal = hv; eId = mq[0].id;
                    void'(mq.pop_front());
                end
                if (issueOk) begin
                    e.id = 3'(mTail); e.rd = bus.issue_rd; e.isBr = bus.issue_is_br;
                    e.pred = bus.issue_pred_taken; e.alt = bus.issue_alt_pc;
                    e.done = 0; e.value = '0; e.taken = 0;
                    mq.push_back(e);
                    mTail = (mTail + 1) % N;
                end
            end
        end
    endtask

    task automatic checkOutput();
        checkVal("commit_valid", bus.commit_valid, eCv);
        checkVal("commit_rd", bus.commit_rd, eRd);
        checkVal("commit_value", bus.commit_value, eVal);
        checkVal("commit_rob_id", bus.commit_rob_id, eId);
        checkVal("flush_out", bus.flush_out, eFl);
        checkVal("flush_pc", bus.flush_pc, ePc);
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic applyStimulus(input bit chkPre);
        #1;
        if (chkPre) checkQuery();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; rdy = 1;
        bus.issue_valid = 0; bus.issue_rd = '0; bus.issue_is_br = 0;
        bus.issue_pred_taken = 0; bus.issue_alt_pc = '0;
        bus.cdb_valid = 0; bus.cdb_rob_id = '0; bus.cdb_value = '0; bus.cdb_taken = 0;
        bus.qry1_id = '0; bus.qry2_id = '0;
    endtask

    task automatic doIssue(input logic [4:0] rdV);
        idle();
        bus.issue_valid = 1; bus.issue_rd = rdV;
        applyStimulus(1);
    endtask

    task automatic doCdb(input logic [2:0] idV, input logic [31:0] valV);
        idle();
        bus.cdb_valid = 1; bus.cdb_rob_id = idV; bus.cdb_value = valV;
        applyStimulus(1);
    endtask

    task automatic doReset();
        idle();
        rst = 1;
        applyStimulus(1);
    endtask

    typedef struct {
        bit          rst;
        bit          iv;
        logic [4:0]  ird;
        bit          ibr;
        bit          ipred;
        logic [31:0] ialt;
        bit          cv;
        logic [2:0]  cid;
        logic [31:0] cval;
        bit          ctaken;
        bit          cvN, cvB, flN, flB, chkN, chkB;
        logic [4:0]  eRd;
        logic [31:0] eVal;
        logic [2:0]  eId;
        logic [31:0] ePc;
        bit          eFull;
        logic [2:0]  tailN, tailB;
    } vec_t;

    function automatic vec_t mkVec(input bit rstV, input bit ivV, input logic [4:0] rdV,
                                   input bit brV, input bit predV, input logic [31:0] altV,
                                   input bit cdbV, input logic [2:0] cidV,
                                   input logic [31:0] cvalV, input bit ctV);
        vec_t v;
        v.rst = rstV; v.iv = ivV; v.ird = rdV; v.ibr = brV; v.ipred = predV; v.ialt = altV;
        v.cv = cdbV; v.cid = cidV; v.cval = cvalV; v.ctaken = ctV;
        v.cvN = 0; v.cvB = 0; v.flN = 0; v.flB = 0; v.chkN = 0; v.chkB = 0;
        v.eRd = '0; v.eVal = '0; v.eId = '0; v.ePc = '0; v.eFull = 0; v.tailN = '0; v.tailB = '0;
        return v;
    endfunction

    function automatic vec_t setExp(input vec_t vi, input bit cvN, input bit cvB,
                                    input bit flN, input bit flB, input bit chkN, input bit chkB,
                                    input logic [4:0] rdV, input logic [31:0] valV,
                                    input logic [2:0] idV, input logic [31:0] pcV,
                                    input bit fullV, input logic [2:0] tN, input logic [2:0] tB);
        vec_t v;
        v = vi;
        v.cvN = cvN; v.cvB = cvB; v.flN = flN; v.flB = flB; v.chkN = chkN; v.chkB = chkB;
        v.eRd = rdV; v.eVal = valV; v.eId = idV; v.ePc = pcV; v.eFull = fullV;
        v.tailN = tN; v.tailB = tB;
        return v;
    endfunction

    vec_t tbl[$];
    int   commitIds[$];

    initial begin
        // Directed table: basic commit, full buffer, mispredict flush.
        tbl.push_back(setExp(mkVec(0,1,5,0,0,0, 0,0,0,0), 0,0,0,0,1,1, 0,0,0,0, 0,1,1));
        tbl.push_back(setExp(mkVec(0,0,0,0,0,0, 1,0,32'h1234,0), 0,1,0,0,0,1, 5,32'h1234,0,0, 0,1,1));
        tbl.push_back(setExp(mkVec(0,0,0,0,0,0, 0,0,0,0), 1,0,0,0,1,1, 5,32'h1234,0,0, 0,1,1));
        tbl.push_back(setExp(mkVec(1,0,0,0,0,0, 0,0,0,0), 0,0,0,0,1,1, 0,0,0,0, 0,0,0));
        for (int k = 1; k <= 8; k++)
            tbl.push_back(setExp(mkVec(0,1,5'(k),0,0,0, 0,0,0,0), 0,0,0,0,1,1, 0,0,0,0,
                                 (k == 8), 3'(k % 8), 3'(k % 8)));
        tbl.push_back(setExp(mkVec(0,1,31,0,0,0, 0,0,0,0), 0,0,0,0,1,1, 0,0,0,0, 1,0,0));
        tbl.push_back(setExp(mkVec(1,0,0,0,0,0, 0,0,0,0), 0,0,0,0,1,1, 0,0,0,0, 0,0,0));
        tbl.push_back(setExp(mkVec(0,1,2,1,0,32'h100, 0,0,0,0), 0,0,0,0,1,1, 0,0,0,0, 0,1,1));
        tbl.push_back(setExp(mkVec(0,1,3,0,0,0, 0,0,0,0), 0,0,0,0,1,1, 0,0,0,0, 0,2,2));
        tbl.push_back(setExp(mkVec(0,0,0,0,0,0, 1,0,32'h55,1), 0,1,0,1,0,1, 0,32'h55,0,32'h100, 0,2,0));
        tbl.push_back(setExp(mkVec(0,0,0,0,0,0, 0,0,0,0), 1,0,1,0,1,1, 0,32'h55,0,32'h100, 0,0,0));
        tbl.push_back(setExp(mkVec(0,0,0,0,0,0, 0,0,0,0), 0,0,0,0,1,1, 0,32'h55,0,32'h100, 0,0,0));

        // Reset with busy inputs; DUT state is unknown until after the first edge.
        idle();
        rst = 1;
        bus.issue_valid = 1; bus.cdb_valid = 1;
        @(negedge clk);
        applyStimulus(0);
        idle();
        #1;
        checkVal("rst_tail", bus.rob_tail_id, 0);
        checkVal("rst_full", bus.rob_full, 0);
        checkVal("rst_qry1_ready", bus.qry1_ready, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            idle();
            rst = tbl[i].rst;
            bus.issue_valid = tbl[i].iv; bus.issue_rd = tbl[i].ird; bus.issue_is_br = tbl[i].ibr;
            bus.issue_pred_taken = tbl[i].ipred; bus.issue_alt_pc = tbl[i].ialt;
            bus.cdb_valid = tbl[i].cv; bus.cdb_rob_id = tbl[i].cid;
            bus.cdb_value = tbl[i].cval; bus.cdb_taken = tbl[i].ctaken;
            applyStimulus(1);
            checkVal($sformatf("tbl%0d_commit_valid", i), bus.commit_valid, BYPASS ? tbl[i].cvB : tbl[i].cvN);
            checkVal($sformatf("tbl%0d_flush_out", i), bus.flush_out, BYPASS ? tbl[i].flB : tbl[i].flN);
            checkVal($sformatf("tbl%0d_full", i), bus.rob_full, tbl[i].eFull);
            checkVal($sformatf("tbl%0d_tail", i), bus.rob_tail_id, BYPASS ? tbl[i].tailB : tbl[i].tailN);
            if (BYPASS ? tbl[i].chkB : tbl[i].chkN) begin
                checkVal($sformatf("tbl%0d_commit_rd", i), bus.commit_rd, tbl[i].eRd);
                checkVal($sformatf("tbl%0d_commit_value", i), bus.commit_value, tbl[i].eVal);
                checkVal($sformatf("tbl%0d_commit_id", i), bus.commit_rob_id, tbl[i].eId);
                checkVal($sformatf("tbl%0d_flush_pc", i), bus.flush_pc, tbl[i].ePc);
            end
        end

        // Out-of-order completion still retires in program order.
        doReset();
        doIssue(7);
        doIssue(9);
        doCdb(1, 32'hA);
        if (bus.commit_valid) commitIds.push_back(int'(bus.commit_rob_id));
        doCdb(0, 32'hB);
        if (bus.commit_valid) commitIds.push_back(int'(bus.commit_rob_id));
        for (int k = 0; k < 3; k++) begin
            idle();
            applyStimulus(1);
            if (bus.commit_valid) commitIds.push_back(int'(bus.commit_rob_id));
        end
        checkVal("order_count", commitIds.size(), 2);
        checkVal("order_first", commitIds.size() > 0 ? commitIds[0] : 32'hFFFF, 0);
        checkVal("order_second", commitIds.size() > 1 ? commitIds[1] : 32'hFFFF, 1);

        // A ready head waits out two stalled cycles, then retires on the first live edge.
        doReset();
        doIssue(4);
        doIssue(6);
        doCdb(1, 32'h11);
        doCdb(0, 32'h22);
        for (int k = 0; k < 2; k++) begin
            idle();
            rdy = 0;
            bus.issue_valid = 1; bus.issue_rd = 5'd12;
            applyStimulus(1);
            checkVal("pause_commit_valid", bus.commit_valid, 0);
        end
        idle();
        applyStimulus(1);
        checkVal("resume_commit_valid", bus.commit_valid, 1);
        checkVal("resume_commit_id", bus.commit_rob_id, BYPASS ? 1 : 0);
        checkVal("resume_commit_value", bus.commit_value, BYPASS ? 32'h11 : 32'h22);

        // Query while the result is on the CDB, and again after it has been captured.
        doReset();
        doIssue(8);
        idle();
        bus.cdb_valid = 1; bus.cdb_rob_id = 0; bus.cdb_value = 7;
        #1;
        checkVal("byp_qry1_ready", bus.qry1_ready, BYPASS ? 1 : 0);
        checkVal("byp_qry1_value", bus.qry1_value, BYPASS ? 7 : 0);
        applyStimulus(1);
        idle();
        #1;
        checkVal("post_qry1_ready", bus.qry1_ready, BYPASS ? 0 : 1);
        checkVal("post_qry1_value", bus.qry1_value, BYPASS ? 0 : 7);
        applyStimulus(1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            idle();
            rst = ($urandom_range(0, 199) == 0);
            rdy = ($urandom_range(0, 99) < 85);
            bus.issue_valid = ($urandom_range(0, 99) < 55);
            bus.issue_rd = 5'($urandom);
            bus.issue_is_br = ($urandom_range(0, 7) == 0);
            bus.issue_pred_taken = 1'($urandom);
            bus.issue_alt_pc = $urandom;
            bus.cdb_valid = ($urandom_range(0, 99) < 40);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                bus.cdb_rob_id = mq[$urandom_range(0, mq.size() - 1)].id;
            else
                bus.cdb_rob_id = 3'($urandom);
            bus.cdb_value = $urandom;
            bus.cdb_taken = 1'($urandom);
            if (mq.size() > 0 && $urandom_range(0, 1) != 0)
                bus.qry1_id = mq[$urandom_range(0, mq.size() - 1)].id;
            else
                bus.qry1_id = 3'($urandom);
            bus.qry2_id = ($urandom_range(0, 3) == 0) ? bus.cdb_rob_id : 3'($urandom);
            applyStimulus(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
